// File: rtl/mem_ctrl.sv
// Data-side memory controller: serialises ROB loads/stores into byte transfers on an 8-bit RAM
// port, with little-endian assembly, sign/zero extension and IO write back-pressure.
module mem_ctrl #(
  parameter int unsigned ADDR_W     = 32,
  parameter logic [1:0]  IO_ADDR_HI = 2'b11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              RN,
  input  logic              WN,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [31:0]       Wvalue,
  input  logic [16:0]       Inst_Name,
  output logic              Mem_Success,
  output logic [31:0]       Read_Value,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full
);

  // Instruction-name codes, mirroring constants.v.
  localparam logic [16:0] INST_LB  = 17'd1;
  localparam logic [16:0] INST_LH  = 17'd2;
  localparam logic [16:0] INST_LW  = 17'd3;
  localparam logic [16:0] INST_LBU = 17'd4;
  localparam logic [16:0] INST_LHU = 17'd5;
  localparam logic [16:0] INST_LWU = 17'd6;
  localparam logic [16:0] INST_SB  = 17'd7;
  localparam logic [16:0] INST_SH  = 17'd8;
  localparam logic [16:0] INST_SW  = 17'd9;

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic [2:0]        n_q;
  logic [2:0]        k_q;
  logic              sext_q;
  logic              wr_q;
  logic              succ_q;

  logic [2:0]  req_n;
  logic        req_sext;
  logic [2:0]  k_nxt;
  logic [1:0]  lane;
  logic [31:0] rd_bytes;
  logic [31:0] rd_ext;
  logic        io_stall_acc;
  logic        io_stall;

  always_comb begin
    req_n    = 3'd4;
    req_sext = 1'b0;
    if (WN) begin
      case (Inst_Name)
        INST_SB: req_n = 3'd1;
        INST_SH: req_n = 3'd2;
        default: ;
      endcase
    end else begin
      case (Inst_Name)
        INST_LB:  begin req_n = 3'd1; req_sext = 1'b1; end
        INST_LBU: req_n = 3'd1;
        INST_LH:  begin req_n = 3'd2; req_sext = 1'b1; end
        INST_LHU: req_n = 3'd2;
        default: ;
      endcase
    end
  end

  assign io_stall_acc = (Addr[17:16] == IO_ADDR_HI) && io_buffer_full;
  assign io_stall     = (addr_q[17:16] == IO_ADDR_HI) && io_buffer_full;
  assign k_nxt        = k_q + 3'd1;
  // In READ, k_q counts cycles since accept; the byte arriving now belongs to lane k_q-1.
  assign lane         = k_q[1:0] - 2'd1;

  always_comb begin
    rd_bytes = rdata_q;
    rd_bytes[{lane, 3'b000} +: 8] = mem_din;
    rd_ext = rd_bytes;
    case (n_q)
      3'd1:    rd_ext = {{24{sext_q & rd_bytes[7]}}, rd_bytes[7:0]};
      3'd2:    rd_ext = {{16{sext_q & rd_bytes[15]}}, rd_bytes[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      n_q        <= 3'd0;
      k_q        <= 3'd0;
      sext_q     <= 1'b0;
      wr_q       <= 1'b0;
      succ_q     <= 1'b1;
      Read_Value <= '0;
      mem_a      <= '0;
      mem_dout   <= '0;
    end else if (rdy) begin
      case (state_q)
        StIdle: begin
          if (RN || WN) begin
            addr_q  <= Addr;
            wdata_q <= Wvalue;
            n_q     <= req_n;
            sext_q  <= req_sext;
            k_q     <= 3'd0;
            succ_q  <= 1'b0;
            mem_a   <= Addr;
            if (WN) begin
              state_q  <= StWrite;
              mem_dout <= Wvalue[7:0];
              wr_q     <= ~io_stall_acc;
            end else begin
              state_q <= StRead;
            end
          end
        end
        StRead: begin
          if (k_q != 3'd0) rdata_q <= rd_bytes;
          if (k_q == n_q) begin
            Read_Value <= rd_ext;
            succ_q     <= 1'b1;
            state_q    <= StDone;
          end else begin
            if (k_nxt < n_q) mem_a <= addr_q + ADDR_W'(k_nxt);
            k_q <= k_nxt;
          end
        end
        StWrite: begin
          if (wr_q) begin
            if (k_nxt == n_q) begin
              wr_q    <= 1'b0;
              succ_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              k_q      <= k_nxt;
              mem_a    <= addr_q + ADDR_W'(k_nxt);
              mem_dout <= wdata_q[{k_nxt[1:0], 3'b000} +: 8];
              wr_q     <= ~io_stall;
            end
          end else if (!io_stall) begin
            wr_q <= 1'b1;
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign Mem_Success = succ_q;
  // Masking with rst keeps an aborted store from landing one more byte on the reset edge.
  assign mem_wr      = wr_q & rdy & ~rst;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: a synchronous RAM model, queues of expected write beats and
// expected Read_Value per completion, plus latency checks per request.
module tb_mem_ctrl;

  localparam logic [16:0] I_LB  = 17'd1;
  localparam logic [16:0] I_LH  = 17'd2;
  localparam logic [16:0] I_LW  = 17'd3;
  localparam logic [16:0] I_LBU = 17'd4;
  localparam logic [16:0] I_LHU = 17'd5;
  localparam logic [16:0] I_LWU = 17'd6;
  localparam logic [16:0] I_SB  = 17'd7;
  localparam logic [16:0] I_SH  = 17'd8;
  localparam logic [16:0] I_SW  = 17'd9;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        RN = 1'b0;
  logic        WN = 1'b0;
  logic [31:0] Addr = '0;
  logic [31:0] Wvalue = '0;
  logic [16:0] Inst_Name = '0;
  logic        Mem_Success;
  logic [31:0] Read_Value;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full = 1'b0;

  mem_ctrl #(.ADDR_W(32), .IO_ADDR_HI(2'b11)) dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .RN             (RN),
    .WN             (WN),
    .Addr           (Addr),
    .Wvalue         (Wvalue),
    .Inst_Name      (Inst_Name),
    .Mem_Success    (Mem_Success),
    .Read_Value     (Read_Value),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .io_buffer_full (io_buffer_full)
  );

  always #5 clk = ~clk;

  // One-cycle-latency RAM; low 18 address bits so wrapped addresses alias correctly.
  logic [7:0] ram [0:262143];
  always @(posedge clk) begin
    if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
    mem_din <= ram[mem_a[17:0]];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  logic [31:0] sb_rv [$];
  logic [39:0] sb_wr [$];
  logic [31:0] last_rv = '0;
  logic        succ_prev = 1'b1;
  logic [39:0] wr_e;
  logic [31:0] rv_e;

  always @(negedge clk) begin
    if (mem_wr === 1'b1) begin
      if (sb_wr.size() == 0) begin
        check_eq("wr_pending", 32'(sb_wr.size()), 32'd1);
      end else begin
        wr_e = sb_wr.pop_front();
        check_eq("wr_addr", mem_a, wr_e[39:8]);
        check_eq("wr_data", {24'b0, mem_dout}, {24'b0, wr_e[7:0]});
      end
    end
    if (Mem_Success === 1'b1 && succ_prev === 1'b0) begin
      if (sb_rv.size() == 0) begin
        check_eq("rv_pending", 32'(sb_rv.size()), 32'd1);
      end else begin
        rv_e = sb_rv.pop_front();
        check_eq("read_value", Read_Value, rv_e);
      end
    end
    succ_prev <= Mem_Success;
  end

  // Entered at #1 after E0; io/rdy are set for each following edge.
  task automatic wait_done(input string tag, input int exp_lat, input int io_cycles,
                           input int rdy_len);
    int lat;
    lat = 0;
    while (Mem_Success !== 1'b1 && lat < 40) begin
      io_buffer_full = (lat + 1 < io_cycles);
      rdy = (lat >= rdy_len);
      @(posedge clk);
      #1;
      lat++;
    end
    io_buffer_full = 1'b0;
    rdy = 1'b1;
    check_eq({tag, "_latency"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic do_req(input string tag, input logic rn, input logic wn, input logic [31:0] a,
                        input logic [31:0] w, input logic [16:0] inst, input logic [31:0] exp_rv,
                        input int exp_lat, input int io_cycles, input int rdy_len,
                        input bit hold);
    int n;
    if (wn) begin
      n = (inst == I_SB) ? 1 : (inst == I_SH) ? 2 : 4;
      for (int i = 0; i < n; i++) sb_wr.push_back({a + 32'(i), 8'(w >> (8 * i))});
      sb_rv.push_back(last_rv);
    end else begin
      sb_rv.push_back(exp_rv);
      last_rv = exp_rv;
    end
    @(posedge clk);
    #1;
    RN = rn;
    WN = wn;
    Addr = a;
    Wvalue = w;
    Inst_Name = inst;
    io_buffer_full = (io_cycles > 0);
    @(posedge clk);
    #1;
    if (!hold) begin
      RN = 1'b0;
      WN = 1'b0;
    end
    check_eq({tag, "_accept"}, {31'b0, Mem_Success}, 32'd0);
    wait_done(tag, exp_lat, io_cycles, rdy_len);
  endtask

  initial begin
    for (int i = 0; i < 262144; i++) ram[i] = 8'h00;
    ram[18'h100] = 8'h11; ram[18'h101] = 8'h22; ram[18'h102] = 8'h33; ram[18'h103] = 8'h84;
    ram[18'h3FFFE] = 8'h01; ram[18'h3FFFF] = 8'h02; ram[18'h0] = 8'h03; ram[18'h1] = 8'h04;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("rst_success", {31'b0, Mem_Success}, 32'd1);
    check_eq("rst_read_value", Read_Value, 32'd0);
    check_eq("rst_mem_a", mem_a, 32'd0);
    check_eq("rst_mem_dout", {24'b0, mem_dout}, 32'd0);
    check_eq("rst_mem_wr", {31'b0, mem_wr}, 32'd0);

    //      tag     rn    wn    addr            wvalue         inst   exp_rv        lat io rdy hold
    do_req("lw",   1'b1, 1'b0, 32'h100,        32'h0,         I_LW,  32'h84332211, 5, 0, 0, 0);
    do_req("lb",   1'b1, 1'b0, 32'h103,        32'h0,         I_LB,  32'hFFFFFF84, 2, 0, 0, 0);
    do_req("lbu",  1'b1, 1'b0, 32'h103,        32'h0,         I_LBU, 32'h00000084, 2, 0, 0, 0);
    do_req("lh",   1'b1, 1'b0, 32'h102,        32'h0,         I_LH,  32'hFFFF8433, 3, 0, 0, 0);
    do_req("lhu",  1'b1, 1'b0, 32'h102,        32'h0,         I_LHU, 32'h00008433, 3, 0, 0, 0);
    do_req("lhp",  1'b1, 1'b0, 32'h100,        32'h0,         I_LH,  32'h00002211, 3, 0, 0, 0);
    do_req("lwu",  1'b1, 1'b0, 32'h100,        32'h0,         I_LWU, 32'h84332211, 5, 0, 0, 0);
    do_req("unk",  1'b1, 1'b0, 32'h101,        32'h0,         17'd0, 32'h00843322, 5, 0, 0, 0);
    do_req("sw",   1'b0, 1'b1, 32'h200,        32'hDEADBEEF,  I_SW,  32'h0,        4, 0, 0, 0);
    do_req("lwrb", 1'b1, 1'b0, 32'h200,        32'h0,         I_LW,  32'hDEADBEEF, 5, 0, 0, 0);
    do_req("sbio", 1'b0, 1'b1, 32'h30000,      32'h123456A5,  I_SB,  32'h0,        4, 3, 0, 0);
    do_req("sbnio",1'b0, 1'b1, 32'h10040,      32'h0000003C,  I_SB,  32'h0,        1, 3, 0, 0);
    do_req("lbio", 1'b1, 1'b0, 32'h30000,      32'h0,         I_LBU, 32'h000000A5, 2, 0, 0, 0);

    // RN stays high through DONE: ignored there, re-accepted on the next IDLE edge.
    do_req("hold", 1'b1, 1'b0, 32'h100,        32'h0,         I_LW,  32'h84332211, 5, 0, 0, 1);
    sb_rv.push_back(32'h84332211);
    @(posedge clk);
    #1;
    check_eq("hold_done_ignored", {31'b0, Mem_Success}, 32'd1);
    @(posedge clk);
    #1;
    check_eq("hold_reaccept", {31'b0, Mem_Success}, 32'd0);
    RN = 1'b0;
    wait_done("hold2", 5, 0, 0);

    do_req("rnwn", 1'b1, 1'b1, 32'h220,        32'h0000005A,  I_SB,  32'h0,        1, 0, 0, 0);
    do_req("lbrw", 1'b1, 1'b0, 32'h220,        32'h0,         I_LB,  32'h0000005A, 2, 0, 0, 0);
    do_req("shrdy",1'b0, 1'b1, 32'h210,        32'h0000CAFE,  I_SH,  32'h0,        4, 0, 2, 0);
    do_req("lhrb", 1'b1, 1'b0, 32'h210,        32'h0,         I_LH,  32'hFFFFCAFE, 3, 0, 0, 0);
    do_req("wrap", 1'b1, 1'b0, 32'hFFFFFFFE,   32'h0,         I_LW,  32'h04030201, 5, 0, 0, 0);

    // Store aborted by reset: two bytes land, then nothing more and Read_Value clears.
    sb_wr.push_back({32'h300, 8'h78});
    sb_wr.push_back({32'h301, 8'h56});
    sb_rv.push_back(32'h0);
    last_rv = 32'h0;
    @(posedge clk);
    #1;
    WN = 1'b1;
    Addr = 32'h300;
    Wvalue = 32'h12345678;
    Inst_Name = I_SW;
    @(posedge clk);
    #1;
    WN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("abort_success", {31'b0, Mem_Success}, 32'd1);
    check_eq("abort_read_value", Read_Value, 32'd0);
    check_eq("abort_mem_wr", {31'b0, mem_wr}, 32'd0);
    repeat (3) @(posedge clk);

    do_req("lbab0",1'b1, 1'b0, 32'h300,        32'h0,         I_LB,  32'h00000078, 2, 0, 0, 0);
    do_req("lbab2",1'b1, 1'b0, 32'h302,        32'h0,         I_LB,  32'h00000000, 2, 0, 0, 0);

    repeat (3) @(posedge clk);
    check_eq("sb_wr_drained", 32'(sb_wr.size()), 32'd0);
    check_eq("sb_rv_drained", 32'(sb_rv.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
